// File: rtl/job_fifo_mc_if.sv
// job_fifo_mc_if: write/read bundle for the multi-channel job FIFO
//  master: producer/consumer side (drives i_*, observes o_*)
//  slave : FIFO side (observes i_*, drives o_*)
//  i_wr, i_wr_ch, i_w_data_d, i_w_data_c : channel-tagged write port
//  i_rd                                  : pop the presented word
//  o_r_valid, o_r_ch, o_r_data_d/c       : FWFT round-robin read port
//  o_empty, o_full, o_afull, o_space     : per-channel status
//  o_drop_cnt                            : saturating count of rejected writes
interface job_fifo_mc_if #(
    parameter int DWIDTH = 64,
    parameter int CWIDTH = 6,
    parameter int DEPTH  = 10,
    parameter int NCH    = 4,
    parameter int CHW    = 2
);
    logic                     i_wr;
    logic [CHW-1:0]           i_wr_ch;
    logic [DWIDTH-1:0]        i_w_data_d;
    logic [CWIDTH-1:0]        i_w_data_c;
    logic                     i_rd;
    logic                     o_r_valid;
    logic [CHW-1:0]           o_r_ch;
    logic [DWIDTH-1:0]        o_r_data_d;
    logic [CWIDTH-1:0]        o_r_data_c;
    logic [NCH-1:0]           o_empty;
    logic [NCH-1:0]           o_full;
    logic [NCH-1:0]           o_afull;
    logic [NCH*(DEPTH+1)-1:0] o_space;
    logic [15:0]              o_drop_cnt;
    modport master (
        output i_wr, i_wr_ch, i_w_data_d, i_w_data_c, i_rd,
        input  o_r_valid, o_r_ch, o_r_data_d, o_r_data_c, o_empty, o_full, o_afull, o_space, o_drop_cnt
    );
    modport slave (
        input  i_wr, i_wr_ch, i_w_data_d, i_w_data_c, i_rd,
        output o_r_valid, o_r_ch, o_r_data_d, o_r_data_c, o_empty, o_full, o_afull, o_space, o_drop_cnt
    );
endinterface

// File: rtl/job_fifo_mc.sv
// job_fifo_mc: NCH circular job queues in one partitioned memory with a round-robin FWFT read port
//  clk   : rising-edge clock
//  reset : asynchronous active-high reset, discards all queued jobs
//  bus   : job_fifo_mc_if.slave (write port, read port, per-channel status, drop counter)
module job_fifo_mc #(
    parameter int DWIDTH    = 64,
    parameter int CWIDTH    = 6,
    parameter int DEPTH     = 10,
    parameter int NCH       = 4,
    parameter int CHW       = 2,
    parameter int AF_THRESH = 16
) (
    input logic          clk,
    input logic          reset,
    job_fifo_mc_if.slave bus
);
    localparam int MW = DWIDTH + CWIDTH;
    localparam logic [DEPTH:0] L_CAP = {1'b1, {DEPTH{1'b0}}};
    logic [MW-1:0]    r_mem [NCH << DEPTH];
    logic [DEPTH-1:0] r_wptr [NCH];
    logic [DEPTH-1:0] r_rptr [NCH];
    logic [DEPTH:0]   r_cnt [NCH];
    logic [DEPTH:0]   r_space [NCH];
    logic [NCH-1:0]   r_empty, r_full, r_afull;
    logic [CHW-1:0]   r_rr;
    logic [15:0]      r_drop;
    logic [CHW-1:0]   w_grant, w_idx;
    logic             w_valid, w_pop, w_wr_ok;
    logic [DEPTH:0]   w_cnt_nxt [NCH];
    logic [DEPTH:0]   w_space_nxt [NCH];
    // scan downwards so the channel closest to r_rr overwrites any later match
    always_comb begin
        w_grant = r_rr;
        w_idx   = r_rr;
        for (int i = NCH - 1; i >= 0; i--) begin
            w_idx = r_rr + CHW'(i);
            if (!r_empty[w_idx]) w_grant = w_idx;
        end
    end
    assign w_valid = ~&r_empty;
    assign w_pop   = bus.i_rd & w_valid;
    // a full channel still takes a write when the same edge pops it
    assign w_wr_ok = bus.i_wr & (~r_full[bus.i_wr_ch] | (w_pop & (w_grant == bus.i_wr_ch)));
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_cnt_nxt[c]   = r_cnt[c] + (DEPTH+1)'(w_wr_ok && (bus.i_wr_ch == CHW'(c)))
                                      - (DEPTH+1)'(w_pop && (w_grant == CHW'(c)));
            w_space_nxt[c] = L_CAP - w_cnt_nxt[c];
        end
    end
    always_ff @(posedge clk)
        if (w_wr_ok) r_mem[{bus.i_wr_ch, r_wptr[bus.i_wr_ch]}] <= {bus.i_w_data_d, bus.i_w_data_c};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_wptr[c]  <= '0;
                r_rptr[c]  <= '0;
                r_cnt[c]   <= '0;
                r_space[c] <= L_CAP;
            end
            r_empty <= '1;
            r_full  <= '0;
            r_afull <= '0;
            r_rr    <= '0;
            r_drop  <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_wr_ok && (bus.i_wr_ch == CHW'(c))) r_wptr[c] <= r_wptr[c] + 1'b1;
                if (w_pop && (w_grant == CHW'(c))) r_rptr[c] <= r_rptr[c] + 1'b1;
                r_cnt[c]   <= w_cnt_nxt[c];
                r_space[c] <= w_space_nxt[c];
                r_empty[c] <= w_cnt_nxt[c] == '0;
                r_full[c]  <= w_cnt_nxt[c] == L_CAP;
                r_afull[c] <= w_space_nxt[c] <= (DEPTH+1)'(AF_THRESH);
            end
            // holding r_rr on the grant keeps the presented word fixed until it is popped
            if (w_valid) r_rr <= w_pop ? w_grant + 1'b1 : w_grant;
            if (bus.i_wr && !w_wr_ok && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
        end
    end
    assign bus.o_r_valid = w_valid;
    assign bus.o_r_ch    = w_grant;
    assign {bus.o_r_data_d, bus.o_r_data_c} = r_mem[{w_grant, r_rptr[w_grant]}];
    assign bus.o_empty    = r_empty;
    assign bus.o_full     = r_full;
    assign bus.o_afull    = r_afull;
    assign bus.o_drop_cnt = r_drop;
    for (genvar g = 0; g < NCH; g++) begin : g_space
        assign bus.o_space[g*(DEPTH+1) +: DEPTH+1] = r_space[g];
    end
endmodule
